cordic_hyp_unit: RTL and testbench

- Parametrised successor to the single-function hyperbolic CORDIC log block, on the calculator datapath between operand decode and the result formatter.
- Iterative engine (one micro-rotation/cycle) computing ln(x) or sqrt(x) of an unsigned fixed-point operand.
- Adds binary range normalisation (full input range), hyperbolic convergence repeats, valid/ready handshake and error flagging.

---
 rtl/cordic_hyp_unit.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_cordic_hyp_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cordic_hyp_unit.sv
// cordic_hyp_unit
//   Iterative hyperbolic CORDIC engine for the calculator datapath. Computes
//   ln(x) or sqrt(x) of an unsigned fixed-point operand, one micro-rotation
//   per enabled clock. The operand is first normalised to a mantissa and a
//   binary exponent, so the whole input range is covered.
//
//   FSM: IDLE -> NORM -> ITER -> POST -> DONE -> IDLE
//   The earliest result handshake edge is NI+3 enabled edges after the accept
//   edge (NI = ITERATIONS + repeated indices). For a zero operand it is 3.
//
// Ports
//   CLK      in   clock, rising edge
//   RST_N    in   asynchronous active-low reset (aborts any operation)
//   i_ce     in   clock enable, all state frozen while low
//   i_valid  in   operand valid
//   o_ready  out  engine idle, operand can be accepted
//   i_mode   in   0 = ln, 1 = sqrt
//   i_val    in   operand, unsigned Q(IW-IFW).IFW
//   o_valid  out  result valid (held until i_ready)
//   i_ready  in   downstream accepts result
//   o_res    out  result, signed Q(OW-OFW).OFW
//   o_err    out  domain error (ln of zero)
//   o_busy   out  engine not idle
module cordic_hyp_unit #(
  parameter int IW         = 16,
  parameter int IFW        = 8,
  parameter int OW         = 24,
  parameter int OFW        = 16,
  parameter int W          = 32,
  parameter int ITERATIONS = 20
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          i_ce,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic          i_mode,
  input  logic [IW-1:0] i_val,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [OW-1:0] o_res,
  output logic          o_err,
  output logic          o_busy
);

  localparam int FB  = 30;                        // working fractional bits
  localparam int KW  = 8;                         // exponent width
  localparam int LW  = $clog2(IW);
  localparam int IXW = $clog2(ITERATIONS + 2);
  localparam int AW  = W + 16;                    // ln post-processing width
  localparam int PW  = 2 * W + 8;                 // sqrt product width

  // atanh(2^-i) in Q.30, evaluated from the odd power series in Q.62.
  function automatic logic [W-1:0] atanh_q(input int i);
    logic [63:0] acc;
    int          e;
    acc = '0;
    if (i > 0) begin
      for (int n = 0; n < 32; n++) begin
        e = i * (2 * n + 1);
        if (e <= 62)
          acc = acc + ((64'd1 << (62 - e)) / 64'(2 * n + 1));
      end
    end
    return W'((acc + (64'd1 << 31)) >> 32);
  endfunction

  // 1/K_h in Q.30 where K_h = prod sqrt(1 - 4^-i) over the executed schedule
  // (indices 4, 13 and 40 counted twice).
  function automatic logic [W-1:0] kinv_q();
    logic [127:0] p, v, r, b;
    int           reps;
    p = 128'd1 << 62;
    for (int i = 1; i <= ITERATIONS; i++) begin
      reps = (i == 4 || i == 13 || i == 40) ? 2 : 1;
      for (int n = 0; n < reps; n++)
        if (2 * i <= 62)
          p = (p * ((128'd1 << 62) - (128'd1 << (62 - 2 * i)))) >> 62;
    end
    // integer square root of p*2^62 gives K_h in Q.62
    v = p << 62;
    r = '0;
    b = 128'd1 << 126;
    for (int j = 0; j < 64; j++) begin
      if (v >= r + b) begin
        v = v - (r + b);
        r = (r >> 1) + b;
      end else begin
        r = r >> 1;
      end
      b = b >> 2;
    end
    return W'(((128'd1 << 92) + (r >> 1)) / r);
  endfunction

  localparam logic signed [W-1:0]  ONE_Q   = W'(64'd1 << FB);
  localparam logic signed [W-1:0]  QTR_Q   = W'(64'd1 << (FB - 2));
  localparam logic signed [AW-1:0] LN2_Q   = AW'(64'd744261118);  // ln2 * 2^30
  localparam logic signed [W-1:0]  KINV_Q  = kinv_q();
  localparam logic signed [PW-1:0] SAT_MAX = (PW'(1) <<< (OW - 1)) - PW'(1);
  localparam logic signed [PW-1:0] SAT_MIN = -(PW'(1) <<< (OW - 1));

  function automatic logic [OW-1:0] sat_ow(input logic signed [PW-1:0] v);
    if (v > SAT_MAX)
      return SAT_MAX[OW-1:0];
    else if (v < SAT_MIN)
      return SAT_MIN[OW-1:0];
    else
      return v[OW-1:0];
  endfunction

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_NORM = 3'd1,
    S_ITER = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                state_reg, state_next;
  logic [IW-1:0]         val_reg, val_next;
  logic                  mode_reg, mode_next;
  logic                  zero_reg, zero_next;
  logic                  rep_reg, rep_next;
  logic signed [W-1:0]   x_reg, x_next;
  logic signed [W-1:0]   y_reg, y_next;
  logic signed [W-1:0]   z_reg, z_next;
  logic signed [KW-1:0]  k_reg, k_next;
  logic [IXW-1:0]        idx_reg, idx_next;
  logic [OW-1:0]         res_reg, res_next;
  logic                  err_reg, err_next;

  logic signed [W-1:0]   atanh_rom [0:ITERATIONS];

  generate
    for (genvar gi = 0; gi <= ITERATIONS; gi++) begin : g_atanh_rom
      assign atanh_rom[gi] = atanh_q(gi);
    end
  endgenerate

  // ---------------------------------------------------------------- NORM
  logic [LW-1:0]         lead_pos;
  logic signed [KW-1:0]  k_raw, k_seed;
  logic [W-1:0]          m_norm;
  logic signed [W-1:0]   m_seed, x_seed, y_seed;

  always_comb begin
    lead_pos = '0;
    for (int b = 0; b < IW; b++)
      if (val_reg[b]) lead_pos = LW'(b);
  end

  // Leading one lands at bit FB-1, i.e. m in [0.5,1) with v = m*2^k.
  // sqrt needs an even exponent: bump k and halve m, giving m in [0.25,0.5).
  always_comb begin
    k_raw  = KW'(int'(lead_pos) + 1 - IFW);
    m_norm = W'(val_reg) << (FB - 1 - int'(lead_pos));
    if (mode_reg && k_raw[0]) begin
      k_seed = k_raw + KW'(1);
      m_seed = $signed(m_norm >> 1);
    end else begin
      k_seed = k_raw;
      m_seed = $signed(m_norm);
    end
    x_seed = m_seed + (mode_reg ? QTR_Q : ONE_Q);
    y_seed = m_seed - (mode_reg ? QTR_Q : ONE_Q);
  end

  // ---------------------------------------------------------------- ITER
  logic signed [W-1:0] x_sh, y_sh;
  logic                is_rep, last_iter;

  assign x_sh = x_reg >>> idx_reg;
  assign y_sh = y_reg >>> idx_reg;
  // Indices 4, 13, 40 run a second time so the hyperbolic sequence converges.
  assign is_rep    = !rep_reg && (int'(idx_reg) == 4 || int'(idx_reg) == 13 ||
                                  int'(idx_reg) == 40);
  assign last_iter = !is_rep && (int'(idx_reg) == ITERATIONS);

  // ---------------------------------------------------------------- POST
  logic signed [AW-1:0] acc_ln, rnd_ln;
  logic signed [PW-1:0] prod_sq, rnd_sq;
  int                   sq_shift;
  logic [OW-1:0]        post_res;
  logic                 post_err;

  // z converges to atanh(y0/x0) = ln(m)/2, so ln(v) = 2z + k*ln2.
  assign acc_ln   = (AW'(z_reg) <<< 1) + AW'(k_reg) * LN2_Q;
  assign rnd_ln   = (acc_ln + (AW'(1) <<< (FB - OFW - 1))) >>> (FB - OFW);
  // x converges to K_h*sqrt(m); product is Q.60, the k/2 scale folds into the
  // final right shift (k/2 may be negative).
  assign prod_sq  = PW'(x_reg) * PW'(KINV_Q);
  assign sq_shift = 2 * FB - OFW - int'(k_reg >>> 1);
  assign rnd_sq   = (prod_sq + (PW'(1) <<< (sq_shift - 1))) >>> sq_shift;

  always_comb begin
    post_err = 1'b0;
    if (zero_reg) begin
      post_res = mode_reg ? '0 : {1'b1, {(OW-1){1'b0}}};
      post_err = !mode_reg;
    end else if (mode_reg) begin
      post_res = sat_ow(rnd_sq);
    end else begin
      post_res = sat_ow(PW'(rnd_ln));
    end
  end

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_next = state_reg;
    val_next   = val_reg;
    mode_next  = mode_reg;
    zero_next  = zero_reg;
    rep_next   = rep_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    z_next     = z_reg;
    k_next     = k_reg;
    idx_next   = idx_reg;
    res_next   = res_reg;
    err_next   = err_reg;
    if (i_ce) begin
      case (state_reg)
        S_IDLE: begin
          if (i_valid) begin
            val_next   = i_val;
            mode_next  = i_mode;
            state_next = S_NORM;
          end
        end
        S_NORM: begin
          idx_next = IXW'(1);
          rep_next = 1'b0;
          z_next   = '0;
          if (val_reg == '0) begin
            zero_next  = 1'b1;
            x_next     = '0;
            y_next     = '0;
            k_next     = '0;
            state_next = S_POST;
          end else begin
            zero_next  = 1'b0;
            x_next     = x_seed;
            y_next     = y_seed;
            k_next     = k_seed;
            state_next = S_ITER;
          end
        end
        S_ITER: begin
          if (!y_reg[W-1]) begin
            x_next = x_reg - y_sh;
            y_next = y_reg - x_sh;
            z_next = z_reg + atanh_rom[idx_reg];
          end else begin
            x_next = x_reg + y_sh;
            y_next = y_reg + x_sh;
            z_next = z_reg - atanh_rom[idx_reg];
          end
          if (is_rep) begin
            rep_next = 1'b1;
          end else begin
            rep_next = 1'b0;
            idx_next = idx_reg + IXW'(1);
          end
          if (last_iter) state_next = S_POST;
        end
        S_POST: begin
          res_next   = post_res;
          err_next   = post_err;
          state_next = S_DONE;
        end
        S_DONE: begin
          if (i_ready) state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= S_IDLE;
      val_reg   <= '0;
      mode_reg  <= 1'b0;
      zero_reg  <= 1'b0;
      rep_reg   <= 1'b0;
      x_reg     <= '0;
      y_reg     <= '0;
      z_reg     <= '0;
      k_reg     <= '0;
      idx_reg   <= '0;
      res_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      val_reg   <= val_next;
      mode_reg  <= mode_next;
      zero_reg  <= zero_next;
      rep_reg   <= rep_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      z_reg     <= z_next;
      k_reg     <= k_next;
      idx_reg   <= idx_next;
      res_reg   <= res_next;
      err_reg   <= err_next;
    end
  end

  assign o_ready = (state_reg == S_IDLE);
  assign o_busy  = (state_reg != S_IDLE);
  assign o_valid = (state_reg == S_DONE);
  assign o_res   = res_reg;
  assign o_err   = err_reg;

endmodule

// File: tb/tb_cordic_hyp_unit.sv
// tb_cordic_hyp_unit
//   Directed-vector bench for cordic_hyp_unit at default parameters.
//   Expected values are hand-computed as round(f(v) * 65536).
module tb_cordic_hyp_unit;

  localparam int IW = 16;
  localparam int OW = 24;

  logic          CLK;
  logic          RST_N;
  logic          i_ce;
  logic          i_valid;
  logic          o_ready;
  logic          i_mode;
  logic [IW-1:0] i_val;
  logic          o_valid;
  logic          i_ready;
  logic [OW-1:0] o_res;
  logic          o_err;
  logic          o_busy;

  int n_checks = 0;
  int n_fail   = 0;

  cordic_hyp_unit dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .i_ce    (i_ce),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_mode  (i_mode),
    .i_val   (i_val),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_res   (o_res),
    .o_err   (o_err),
    .o_busy  (o_busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input longint got, input longint exp,
                           input longint tol = 0);
    longint d;
    n_checks++;
    d = got - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
    end else begin
      $display("ok   %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  // Issue one operand and wait for the result handshake. cyc counts clock
  // edges from the accept edge to the handshake edge.
  task automatic run_op(input string tag, input logic mode, input logic [IW-1:0] val,
                        input bit toggle_ce, output longint res, output logic err,
                        output int cyc);
    bit   done;
    logic v;
    @(negedge CLK);
    i_ce    = 1'b1;
    i_mode  = mode;
    i_val   = val;
    i_valid = 1'b1;
    check_val({tag, " ready"}, longint'(o_ready), 1);
    @(posedge CLK);
    cyc  = 0;
    done = 1'b0;
    res  = 0;
    err  = 1'b0;
    while (!done && cyc < 400) begin
      @(negedge CLK);
      i_valid = 1'b0;
      if (toggle_ce) i_ce = ~i_ce;
      v   = o_valid;
      res = longint'($signed(o_res));
      err = o_err;
      @(posedge CLK);
      cyc++;
      if (v && i_ce && i_ready) done = 1'b1;
    end
    if (!done) check_val({tag, " timeout"}, 0, 1);
  endtask

  task automatic op_check(input string tag, input logic mode, input logic [IW-1:0] val,
                          input longint exp_res, input longint tol, input logic exp_err,
                          input int exp_cyc, input bit toggle_ce);
    longint res;
    logic   err;
    int     cyc;
    run_op(tag, mode, val, toggle_ce, res, err, cyc);
    check_val({tag, " res"}, res, exp_res, tol);
    check_val({tag, " err"}, longint'(err), longint'(exp_err));
    check_val({tag, " latency"}, longint'(cyc), longint'(exp_cyc));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic   held_ok, rdy_seen, seen_valid;
    logic [OW-1:0] held;
    int     cnt;

    i_ce    = 1'b1;
    i_valid = 1'b0;
    i_mode  = 1'b0;
    i_val   = '0;
    i_ready = 1'b1;
    RST_N   = 1'b1;
    #1 RST_N = 1'b0;
    #20;
    check_val("rst o_valid", longint'(o_valid), 0);
    check_val("rst o_res",   longint'(o_res),   0);
    check_val("rst o_err",   longint'(o_err),   0);
    check_val("rst o_busy",  longint'(o_busy),  0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check_val("rst o_ready", longint'(o_ready), 1);

    // ln(2)=0.693147 ; ln(1)=0 ; ln(1/256)=-5.545177 ;
    // ln(65535/256)=5.545177-1.526e-5=5.545162 -> 363408
    op_check("ln 2.0",    1'b0, 16'h0200,   45426, 4, 1'b0, 25, 1'b0);
    op_check("ln 1.0",    1'b0, 16'h0100,       0, 4, 1'b0, 25, 1'b0);
    op_check("ln 1/256",  1'b0, 16'h0001, -363409, 4, 1'b0, 25, 1'b0);
    op_check("ln max",    1'b0, 16'hFFFF,  363408, 4, 1'b0, 25, 1'b0);
    op_check("ln 0",      1'b0, 16'h0000, -8388608, 0, 1'b1, 3, 1'b0);
    op_check("sqrt 0",    1'b1, 16'h0000,       0, 0, 1'b0, 3, 1'b0);
    // sqrt(4)=2 ; sqrt(2)=1.414214 ; sqrt(1/256)=1/16 ; sqrt(3)=1.732051 ;
    // sqrt(65535/256)=15.999878
    op_check("sqrt 4.0",  1'b1, 16'h0400,  131072, 4, 1'b0, 25, 1'b0);
    op_check("sqrt 2.0",  1'b1, 16'h0200,   92682, 4, 1'b0, 25, 1'b0);
    op_check("sqrt 1/256",1'b1, 16'h0001,    4096, 4, 1'b0, 25, 1'b0);
    op_check("sqrt 3.0",  1'b1, 16'h0300,  113512, 4, 1'b0, 25, 1'b0);
    op_check("sqrt max",  1'b1, 16'hFFFF, 1048568, 4, 1'b0, 25, 1'b0);

    // Backpressure: result held for 10 cycles, second operand ignored.
    @(negedge CLK);
    i_ready = 1'b0;
    i_mode  = 1'b1;
    i_val   = 16'h0400;
    i_valid = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    i_valid = 1'b0;
    cnt = 0;
    while (!o_valid && cnt < 100) begin
      @(negedge CLK);
      cnt++;
    end
    check_val("bp o_valid", longint'(o_valid), 1);
    held     = o_res;
    held_ok  = 1'b1;
    rdy_seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      i_valid = 1'b1;
      i_mode  = 1'b0;
      i_val   = 16'h0100;
      if (o_res !== held || o_valid !== 1'b1) held_ok = 1'b0;
      if (o_ready) rdy_seen = 1'b1;
    end
    check_val("bp res", longint'($signed(held)), 131072, 4);
    check_val("bp held", longint'(held_ok), 1);
    check_val("bp ready", longint'(rdy_seen), 0);
    @(negedge CLK);
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge CLK);
    check_val("bp release valid", longint'(o_valid), 0);
    check_val("bp release busy",  longint'(o_busy), 0);
    op_check("after bp ln 2.0", 1'b0, 16'h0200, 45426, 4, 1'b0, 25, 1'b0);

    // Reset pulse in the middle of the iterations.
    @(negedge CLK);
    i_mode  = 1'b1;
    i_val   = 16'h0200;
    i_valid = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    i_valid = 1'b0;
    repeat (10) @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    check_val("midrst busy",  longint'(o_busy),  0);
    check_val("midrst valid", longint'(o_valid), 0);
    check_val("midrst res",   longint'(o_res),   0);
    check_val("midrst err",   longint'(o_err),   0);
    @(negedge CLK);
    RST_N = 1'b1;
    seen_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (o_valid) seen_valid = 1'b1;
    end
    check_val("midrst no result", longint'(seen_valid), 0);

    // Clock enable toggling every cycle doubles the edge count.
    op_check("ce toggle ln 2.0", 1'b0, 16'h0200, 45426, 4, 1'b0, 50, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
